// File: rtl/descriptor_beat_packer.sv
// Packs signed int8 descriptor elements into 8-lane, 64-bit AXI-Stream beats.
// Short descriptors are zero-padded to DESC_LEN; framing errors raise sticky flags.
module descriptor_beat_packer #(
  parameter int DESC_LEN = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  s_axis_elem_tdata,
  input  logic        s_axis_elem_tvalid,
  input  logic        s_axis_elem_tlast,
  output logic        s_axis_elem_tready,
  output logic [63:0] m_axis_raw_tdata,
  output logic        m_axis_raw_tvalid,
  output logic        m_axis_raw_tlast,
  input  logic        m_axis_raw_tready,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] desc_count
);

  // state | meaning
  // FILL  | accepting elements into the pack register
  // PAD   | descriptor ended early; emitting zero beats up to the final beat

  localparam int BEATS = DESC_LEN / 8;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    FILL = 1'b0,
    PAD  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    lane_q, lane_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [55:0]   pack_q, pack_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic [15:0]   count_q, count_d;

  logic          slot_free;
  logic          beat_done;
  logic          last_beat;
  logic          accept;
  logic          m_hs;
  logic [63:0]   new_beat;

  assign slot_free = !out_valid_q || m_axis_raw_tready;
  assign beat_done = (lane_q == 3'd7) || s_axis_elem_tlast;
  assign last_beat = (beat_q == LAST_BEAT);
  assign accept    = s_axis_elem_tvalid && s_axis_elem_tready;
  assign m_hs      = out_valid_q && m_axis_raw_tready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept && beat_done && !last_beat && s_axis_elem_tlast) begin
          state_d = PAD;
        end
      end
      PAD: begin
        if (slot_free && last_beat) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Only beat-completing elements need the output slot, so ready is gated on it
  // combinationally and other elements never stall.
  always_comb begin
    s_axis_elem_tready = rstn && (state_q == FILL) && (slot_free || !beat_done);
  end

  always_comb begin
    new_beat = '0;
    for (int i = 0; i < 7; i++) begin
      if (3'(i) < lane_q) begin
        new_beat[i*8 +: 8] = pack_q[i*8 +: 8];
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (3'(i) == lane_q) begin
        new_beat[i*8 +: 8] = s_axis_elem_tdata;
      end
    end
  end

  always_comb begin
    lane_d      = lane_q;
    beat_d      = beat_q;
    pack_d      = pack_q;
    out_valid_d = out_valid_q && !m_axis_raw_tready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    count_d     = count_q;

    if (m_hs && out_last_q) begin
      count_d = count_q + 16'd1;
    end

    if (accept && !beat_done) begin
      for (int i = 0; i < 7; i++) begin
        if (3'(i) == lane_q) begin
          pack_d[i*8 +: 8] = s_axis_elem_tdata;
        end
      end
      lane_d = lane_q + 3'd1;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = new_beat;
      out_last_d  = last_beat;
      lane_d      = 3'd0;
      if (last_beat) begin
        beat_d = '0;
        if (!s_axis_elem_tlast) begin
          err_long_d = 1'b1;
        end
      end else begin
        beat_d = beat_q + 1'b1;
        if (s_axis_elem_tlast) begin
          err_short_d = 1'b1;
        end
      end
    end else if (state_q == PAD && slot_free) begin
      out_valid_d = 1'b1;
      out_data_d  = '0;
      out_last_d  = last_beat;
      beat_d      = last_beat ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lane_q      <= '0;
      beat_q      <= '0;
      pack_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      lane_q      <= lane_d;
      beat_q      <= beat_d;
      pack_q      <= pack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      count_q     <= count_d;
    end
  end

  assign m_axis_raw_tdata  = out_data_q;
  assign m_axis_raw_tvalid = out_valid_q;
  assign m_axis_raw_tlast  = out_last_q;
  assign err_short         = err_short_q;
  assign err_long          = err_long_q;
  assign desc_count        = count_q;

endmodule

// File: tb/tb_descriptor_beat_packer.sv
// Directed bench for descriptor_beat_packer: expected beats come from padding each
// descriptor to DESC_LEN and slicing it into 8-byte words.
module tb_descriptor_beat_packer;
  localparam int DESC_LEN = 256;
  localparam int BEATS = DESC_LEN / 8;

  logic        clk;
  logic        rstn;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        err_short;
  logic        err_long;
  logic [15:0] desc_count;

  descriptor_beat_packer #(.DESC_LEN(DESC_LEN)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .s_axis_elem_tdata  (s_tdata),
    .s_axis_elem_tvalid (s_tvalid),
    .s_axis_elem_tlast  (s_tlast),
    .s_axis_elem_tready (s_tready),
    .m_axis_raw_tdata   (m_tdata),
    .m_axis_raw_tvalid  (m_tvalid),
    .m_axis_raw_tlast   (m_tlast),
    .m_axis_raw_tready  (m_tready),
    .err_short          (err_short),
    .err_long           (err_long),
    .desc_count         (desc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          stalls;
  int          idx;
  logic        mon_en;
  logic        rnd_en;
  logic [7:0]  desc_buf[$];
  logic [64:0] exp_q[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pads desc_buf to one full descriptor and appends its beats to exp_q.
  task automatic add_desc();
    for (int b = 0; b < BEATS; b++) begin
      logic [63:0] w;
      w = '0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < desc_buf.size()) w[i*8 +: 8] = desc_buf[b*8+i];
      end
      exp_q.push_back({(b == BEATS - 1), w});
    end
    desc_buf.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input int budget);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (s_tready) break;
      stalls++;
      if (c >= budget) begin
        chk("s_tready_wait", {64'd0, s_tready}, 65'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int budget);
    for (int c = 0; c < budget && idx < exp_q.size(); c++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 65'(idx), 65'(exp_q.size()));
    chk({tag, "_drained"}, {64'd0, m_tvalid}, 65'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, {64'd0, s_tready}, 65'd0);
    chk({tag, "_m_tvalid"}, {64'd0, m_tvalid}, 65'd0);
    chk({tag, "_m_tlast"}, {64'd0, m_tlast}, 65'd0);
    chk({tag, "_m_tdata"}, {1'b0, m_tdata}, 65'd0);
    chk({tag, "_err_short"}, {64'd0, err_short}, 65'd0);
    chk({tag, "_err_long"}, {64'd0, err_long}, 65'd0);
    chk({tag, "_desc_count"}, 65'(desc_count), 65'd0);
  endtask

  task automatic chk_status(input string tag, input int cnt, input logic es, input logic el);
    chk({tag, "_desc_count"}, 65'(desc_count), 65'(cnt));
    chk({tag, "_err_short"}, {64'd0, err_short}, {64'd0, es});
    chk({tag, "_err_long"}, {64'd0, err_long}, {64'd0, el});
  endtask

  function automatic logic [7:0] f_long(input int n);
    logic [31:0] v;
    v = 32'(n);
    return v[7:0] ^ 8'hA5;
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    stalls   = 0;
    idx      = 0;
    mon_en   = 1'b0;
    rnd_en   = 1'b0;
    rstn     = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    fork
      forever begin
        @(posedge clk);
        #1;
        m_tready = rnd_en ? ($urandom_range(9, 0) < 3) : 1'b1;
      end
      // Every cycle a beat is presented it must equal the next expected beat,
      // which also proves it holds steady while stalled.
      forever begin
        @(negedge clk);
        if (mon_en && m_tvalid) begin
          if (idx < exp_q.size()) chk("beat", {m_tlast, m_tdata}, exp_q[idx]);
          if (m_tready) idx++;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {64'd0, s_tready}, 65'd1);
    @(posedge clk);
    #1;

    // Clean descriptor, ready held high
    exp_q.delete();
    for (int n = 0; n < DESC_LEN; n++) desc_buf.push_back(8'(n));
    add_desc();
    idx = 0;
    mon_en = 1'b1;
    stalls = 0;
    for (int n = 0; n < DESC_LEN; n++) begin
      send(8'(n), n == DESC_LEN - 1, 200);
      if (n == 7) begin
        chk("first_beat_latency", {63'd0, m_tvalid, m_tlast}, 65'd2);
        chk("first_beat_data", {1'b0, m_tdata}, 65'h0_0706050403020100);
      end
    end
    wait_beats("clean_beats", 200);
    chk("clean_stalls", 65'(stalls), 65'd0);
    chk_status("clean", 1, 1'b0, 1'b0);

    // Same stream with 30% downstream ready
    exp_q.delete();
    for (int n = 0; n < DESC_LEN; n++) desc_buf.push_back(8'(n));
    add_desc();
    idx = 0;
    rnd_en = 1'b1;
    for (int n = 0; n < DESC_LEN; n++) send(8'(n), n == DESC_LEN - 1, 500);
    for (int c = 0; c < 3000 && idx < exp_q.size(); c++) @(negedge clk);
    rnd_en = 1'b0;
    wait_beats("bp_beats", 10);
    chk_status("bp", 2, 1'b0, 1'b0);

    // Short descriptor: 13 x 0x7F
    exp_q.delete();
    for (int n = 0; n < 13; n++) desc_buf.push_back(8'h7F);
    add_desc();
    idx = 0;
    for (int n = 0; n < 13; n++) send(8'h7F, n == 12, 200);
    wait_beats("short_beats", 200);
    chk_status("short", 3, 1'b1, 1'b0);

    // Long input: 260 elements without tlast, then one closing element
    exp_q.delete();
    for (int n = 0; n < DESC_LEN; n++) desc_buf.push_back(f_long(n));
    add_desc();
    for (int n = DESC_LEN; n < DESC_LEN + 4; n++) desc_buf.push_back(f_long(n));
    desc_buf.push_back(8'h11);
    add_desc();
    idx = 0;
    for (int n = 0; n < DESC_LEN + 4; n++) send(f_long(n), 1'b0, 200);
    send(8'h11, 1'b1, 200);
    wait_beats("long_beats", 300);
    chk("long_next_first_beat", exp_q[BEATS], 65'h0_00000011A6A7A4A5);
    chk_status("long", 5, 1'b1, 1'b1);

    // Mid-descriptor reset, then a clean descriptor
    exp_q.delete();
    for (int n = 0; n < DESC_LEN; n++) desc_buf.push_back(8'(n));
    add_desc();
    idx = 0;
    for (int n = 0; n < 100; n++) send(8'(n), 1'b0, 200);
    chk("pre_reset_beats", 65'(idx), 65'd12);
    mon_en = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idx = 0;
    mon_en = 1'b1;
    for (int n = 0; n < DESC_LEN; n++) send(8'(n), n == DESC_LEN - 1, 200);
    wait_beats("after_reset_beats", 200);
    repeat (10) @(posedge clk);
    #1;
    chk("after_reset_exact_beats", 65'(idx), 65'd32);
    chk_status("after_reset", 1, 1'b0, 1'b0);

    // Back-to-back: three clean descriptors from a fresh reset
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < DESC_LEN; n++) desc_buf.push_back(8'(n));
      add_desc();
    end
    idx = 0;
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < DESC_LEN; n++) send(8'(n), n == DESC_LEN - 1, 200);
    end
    wait_beats("b2b_beats", 200);
    chk("b2b_stalls", 65'(stalls), 65'd0);
    chk_status("b2b", 3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/descriptor_beat_packer.md
# descriptor_beat_packer

Packs a serial stream of signed 8-bit descriptor elements into 64-bit, 8-lane AXI-Stream beats and frames each descriptor with `tlast`. It drives the raw-descriptor input of the sum-of-squares stage in the descriptor L2-normalisation path. Short descriptors are zero-padded to the full length, so the downstream squared sum is unaffected by the padding. Framing errors are flagged.

## Interface
- `DESC_LEN`, 256: elements per descriptor; a multiple of 8 and ≥ 16.
- `BEATS`, `DESC_LEN/8` (localparam): 64-bit beats per descriptor.
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `s_axis_elem_tdata` in 8: signed int8 descriptor element.
- `s_axis_elem_tvalid` in 1: element valid.
- `s_axis_elem_tlast` in 1: last element of this descriptor, as the producer sees it.
- `s_axis_elem_tready` out 1: element accepted when high together with `tvalid`.
- `m_axis_raw_tdata` out 64: packed beat; element n of the beat is at bits [n*8+7 : n*8].
- `m_axis_raw_tvalid` out 1: beat valid.
- `m_axis_raw_tlast` out 1: final beat (index `BEATS-1`) of a descriptor.
- `m_axis_raw_tready` in 1: downstream ready.
- `err_short` out 1: sticky; a descriptor ended early on input `tlast` and was padded.
- `err_long` out 1: sticky; input ran past `DESC_LEN` without `tlast`.
- `desc_count` out 16: number of descriptors fully emitted; wraps from 65535 to 0.

## Operation
- Internal state:
  - `lane_idx` (3 b) and `beat_idx` (log2 `BEATS` b) count position within the descriptor.
  - A 56-bit pack register holds lanes 0..6.
  - A one-entry output register (`out_valid`, data, last) feeds the master port.
- FSM states: `FILL` (accept elements) and `PAD` (emit zero beats). Reset state is `FILL`.
- `slot_free` = `!out_valid || m_axis_raw_tready`.
- `s_axis_elem_tready` is high only when all of the following hold:
  - `rstn` is high;
  - the state is `FILL`;
  - `slot_free` is true, or the element will not complete a beat. A beat is completed by `lane_idx == 7` or by `s_axis_elem_tlast`.
- Accepting an element with `lane_idx < 7` and no `tlast`: write the element to lane `lane_idx` and increment `lane_idx`.
- Completing a beat: load the output register with the pack-register lanes below `lane_idx`, the current element in lane `lane_idx`, and zero in all lanes above it. Then set `lane_idx` to 0.
  - If `beat_idx == BEATS-1`: set out last = 1, set `beat_idx` to 0, stay in `FILL`.
  - Else, if input `tlast` was set: set `err_short`, increment `beat_idx`, go to `PAD`.
  - Else: increment `beat_idx`.
- At `beat_idx == BEATS-1` and `lane_idx == 7` with input `tlast` low, the beat closes normally and `err_long` is set. The next element starts a new descriptor.
- Input `tlast` on exactly element `DESC_LEN-1` is the normal case. No error flag is set.
- In `PAD`, each cycle with `slot_free` loads an all-zero beat and increments `beat_idx`. The beat with `beat_idx == BEATS-1` carries last = 1 and returns the FSM to `FILL`.
- `desc_count` increments on each master handshake with `tlast` high.
- Reset: all counters, the pack register and the output register clear, and the FSM goes to `FILL`. A partially packed descriptor is discarded. Error flags clear only on reset.

## Timing
- Reset values:
  - `s_axis_elem_tready` = 0 while `rstn` is low, then 1 on the first cycle after reset.
  - `m_axis_raw_tvalid`, `m_axis_raw_tlast`, `m_axis_raw_tdata`, `err_short`, `err_long` and `desc_count` = 0.
- Latency: when the beat-completing element is accepted at cycle T, `m_axis_raw_tvalid` is high at T+1.
- Throughput:
  - One element per cycle with no bubble at beat boundaries while `m_axis_raw_tready` is high.
  - In `PAD`, one zero beat per cycle.
- Backpressure:
  - Master data, last and valid are stable while `tvalid && !tready`.
  - Input stalls only on beat-completing elements.
- `s_axis_elem_tready` is combinational from `m_axis_raw_tready`. All master outputs are registered.
- Arithmetic: element bits are copied verbatim. No sign extension and no saturation.

## Test plan
- Clean descriptor: 256 elements of value n mod 256 with `tlast` on #255 and `m_axis_raw_tready` held at 1 → 32 beats, first beat `0x0706050403020100`, `tlast` only on beat 31, `desc_count` = 1, no error flags.
- Backpressure: random `m_axis_raw_tready` at 30% on the same stream → identical beat sequence, data held stable while stalled, no loss or duplication.
- Short descriptor: 13 elements of 0x7F with `tlast` on #12 → beat 0 all 0x7F, beat 1 `0x000000_7F7F7F7F7F`, beats 2–31 zero, `tlast` on beat 31, `err_short` = 1.
- Long input: 260 elements with no `tlast` → 32 beats ending in `tlast`, `err_long` = 1, elements 256–259 appear in lanes 0–3 of the first beat of the next descriptor.
- Mid-descriptor reset: assert `rstn` low after 100 elements, then send a clean descriptor → exactly 32 beats, all outputs were 0 during reset, `desc_count` = 1.
- Back-to-back: 3 clean descriptors with `m_axis_raw_tready` at 1 → 768 input cycles with no stall, `desc_count` = 3.
